power_effect_controller: RTL

//  Consumes the power-up generator outputs (PowOn + one-hot-ish type flags) and turns a caught

---
 rtl/power_effect_controller.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/power_effect_controller.sv
// -----------------------------------------------------------------------------
// power_effect_controller
//
// Turns a caught power-up into a timed game effect. A catch is the rising edge
// of PowOn. The type flags are sampled on that edge and resolved by fixed
// priority. Timed types (paddle up/down, ball up/down, wrap) override any
// running effect and run for DURATION frames. lifeUp adds a life and does not
// touch the running effect. All outputs are registered.
//
// Ports
//   frame_clk          in   frame clock; all state changes on its rising edge
//   Reset_n            in   asynchronous active-low reset
//   levelChange        in   cancels the active effect; lives are kept
//   noMore             in   cancels the active effect and reloads lives
//   PowOn              in   high while a caught power-up is in force
//   PaddleSizeUpPow .. lifeUp   in   power-up type flags, sampled on the catch
//   life_lost          in   one-cycle pulse: the ball was missed
//   paddleSize   [9:0] out  current paddle width
//   ballSize     [9:0] out  current ball radius
//   wrap_en            out  the ball wraps horizontally instead of bouncing
//   lives        [2:0] out  remaining lives
//   game_over          out  high while lives == 0
//   effect_active      out  high while a timed effect runs
//   frames_left  [9:0] out  frames remaining in the effect (0 when idle)
// -----------------------------------------------------------------------------
module power_effect_controller #(
  parameter int PADDLE_DEFAULT = 80,
  parameter int PADDLE_BIG     = 120,
  parameter int PADDLE_SMALL   = 40,
  parameter int BALL_DEFAULT   = 4,
  parameter int BALL_BIG       = 8,
  parameter int BALL_SMALL     = 2,
  parameter int DURATION       = 600,
  parameter int START_LIVES    = 3,
  parameter int MAX_LIVES      = 7
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       levelChange,
  input  logic       noMore,
  input  logic       PowOn,
  input  logic       PaddleSizeUpPow,
  input  logic       PaddleSizeDownPow,
  input  logic       ballSizeUp,
  input  logic       ballSizeDown,
  input  logic       wrapAround,
  input  logic       lifeUp,
  input  logic       life_lost,
  output logic [9:0] paddleSize,
  output logic [9:0] ballSize,
  output logic       wrap_en,
  output logic [2:0] lives,
  output logic       game_over,
  output logic       effect_active,
  output logic [9:0] frames_left
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  typedef enum logic [2:0] {
    POW_NONE,
    POW_PADDLE_UP,
    POW_PADDLE_DOWN,
    POW_BALL_UP,
    POW_BALL_DOWN,
    POW_WRAP,
    POW_LIFE
  } pow_kind_t;

  state_t    state_q, state_d;
  pow_kind_t kind;
  logic      pow_on_q;
  logic      catch_evt;
  logic      timed_catch;
  logic      life_up_evt;
  logic [3:0] lives_sum;

  logic [9:0] paddle_d, ball_d, frames_d;
  logic       wrap_d, game_over_d;
  logic [2:0] lives_d;

  // A catch while the game is over is ignored entirely.
  assign catch_evt = PowOn & ~pow_on_q & ~game_over;

  // Fixed-priority type resolution of the flags present at the catch.
  always_comb begin
    kind = POW_NONE;
    if      (PaddleSizeUpPow)   kind = POW_PADDLE_UP;
    else if (PaddleSizeDownPow) kind = POW_PADDLE_DOWN;
    else if (ballSizeUp)        kind = POW_BALL_UP;
    else if (ballSizeDown)      kind = POW_BALL_DOWN;
    else if (wrapAround)        kind = POW_WRAP;
    else if (lifeUp)            kind = POW_LIFE;
  end

  // noMore and levelChange both outrank a catch.
  assign timed_catch = catch_evt & ~noMore & ~levelChange &
                       (kind != POW_NONE) & (kind != POW_LIFE);
  assign life_up_evt = catch_evt & ~noMore & ~levelChange & (kind == POW_LIFE);

  assign effect_active = (state_q == ACTIVE);

  // Next-state and next-output logic.
  // NOTE: every variable gets a default at the top so no path leaves one
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d   = state_q;
    paddle_d  = paddleSize;
    ball_d    = ballSize;
    wrap_d    = wrap_en;
    frames_d  = frames_left;
    lives_sum = {1'b0, lives} + {3'b000, life_up_evt};

    if (noMore || levelChange) begin
      state_d  = IDLE;
      paddle_d = 10'(PADDLE_DEFAULT);
      ball_d   = 10'(BALL_DEFAULT);
      wrap_d   = 1'b0;
      frames_d = '0;
    end else if (timed_catch) begin
      // Effects never stack: start from defaults, then apply the new type.
      state_d  = ACTIVE;
      frames_d = 10'(DURATION);
      paddle_d = 10'(PADDLE_DEFAULT);
      ball_d   = 10'(BALL_DEFAULT);
      wrap_d   = 1'b0;
      case (kind)
        POW_PADDLE_UP:   paddle_d = 10'(PADDLE_BIG);
        POW_PADDLE_DOWN: paddle_d = 10'(PADDLE_SMALL);
        POW_BALL_UP:     ball_d   = 10'(BALL_BIG);
        POW_BALL_DOWN:   ball_d   = 10'(BALL_SMALL);
        POW_WRAP:        wrap_d   = 1'b1;
        default:         ;
      endcase
    end else if (state_q == ACTIVE) begin
      if (frames_left == 10'd1) begin
        state_d  = IDLE;
        paddle_d = 10'(PADDLE_DEFAULT);
        ball_d   = 10'(BALL_DEFAULT);
        wrap_d   = 1'b0;
        frames_d = '0;
      end else begin
        frames_d = frames_left - 10'd1;
      end
    end

    // Add first, then subtract, then saturate: a lifeUp and a life_lost in
    // the same cycle cancel even when lives is already at MAX_LIVES.
    if (life_lost && lives_sum != 4'd0) lives_sum = lives_sum - 4'd1;
    if (lives_sum > 4'(MAX_LIVES))      lives_sum = 4'(MAX_LIVES);

    if (noMore) lives_d = 3'(START_LIVES);
    else        lives_d = lives_sum[2:0];

    game_over_d = (lives_d == 3'd0);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      pow_on_q    <= 1'b0;
      paddleSize  <= 10'(PADDLE_DEFAULT);
      ballSize    <= 10'(BALL_DEFAULT);
      wrap_en     <= 1'b0;
      lives       <= 3'(START_LIVES);
      game_over   <= 1'b0;
      frames_left <= '0;
    end else begin
      state_q     <= state_d;
      pow_on_q    <= PowOn;
      paddleSize  <= paddle_d;
      ballSize    <= ball_d;
      wrap_en     <= wrap_d;
      lives       <= lives_d;
      game_over   <= game_over_d;
      frames_left <= frames_d;
    end
  end

endmodule
